mproc_seq: RTL and testbench
============================

// Module: mproc_seq
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the 16-bit mproc datapath (pc, ir, reg_alu).
//  Issues one-cycle strobes (load_ir, pc_inc, wr_reg, jump_en) to the datapath.
//  Handles the instruction-memory handshake with a wait-state timeout.
//  Provides run/halt control plus a retired-instruction counter; instruction field decode stays outside.
// PARAMETERS
//  WAIT_MAX  15  max consecutive FETCH cycles without mem_ack before timeout error (1..255)
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  run        in   1      level: 1 = execute, 0 = stop at next instruction boundary
//  ins_class  in   2      class of IR contents: 00 ALU, 01 LDI (sel path), 10 JUMP, 11 HALT
//  mem_ack    in   1      memory returns valid d_in this cycle (honoured only while mem_req=1)
//  mem_req    out  1      instruction fetch request, held until mem_ack
//  load_ir    out  1      IR load strobe
//  pc_inc     out  1      PC advance strobe
//  wr_reg     out  1      register-file write strobe
//  jump_en    out  1      enables jump (datapath ANDs with cout)
//  busy       out  1      1 in FETCH/DECODE/EXEC
//  halted     out  1      1 in HALTED
//  err_to     out  1      sticky fetch-timeout flag
//  instr_cnt  out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; instr_cnt=0; wait counter=0.
//  States: IDLE, FETCH, DECODE, EXEC, HALTED, ERR (encoded in 3 bits).
//  IDLE: run=1 -> FETCH next cycle; otherwise stay.
//  FETCH: mem_req=1. On mem_ack: load_ir=1 in the same cycle (Mealy), clear wait counter -> DECODE.
//   Without mem_ack: wait counter +1; on reaching WAIT_MAX -> ERR, mem_req drops.
//   run falling during FETCH does not abandon the request; the fetch completes.
//  DECODE: one cycle; ins_class valid from IR; no strobes -> EXEC.
//  EXEC (single cycle, strobes per class):
//   ALU: wr_reg=1, pc_inc=1.
//   LDI: wr_reg=1, pc_inc=1.
//   JUMP: jump_en=1, pc_inc=1.
//   HALT: no strobes -> HALTED.
//   Non-HALT instructions: instr_cnt+1, wrapping all-ones -> 0; next = run ? FETCH : IDLE.
//   HALT is not counted.
//  HALTED: halted=1; leaves only when run=0 (-> IDLE), so restart needs a run low/high cycle.
//  ERR: err_to=1, all strobes 0; exits only by reset.
//  Throughput: 3 cycles/instruction at zero wait states; +1 cycle per FETCH wait cycle.
//  Strobes are at most one cycle wide, and no two EXEC strobes cross instruction boundaries.
//  mem_ack outside FETCH is ignored.
//  Reset mid-instruction: immediate return to IDLE; partial instruction discarded.
// CONFIGURATION
//  MPROC_SEQ_STEP_EN defined: extra input step (1 bit) and state PAUSE.
//   After every EXEC with run=1 -> PAUSE; PAUSE -> FETCH on step=1; PAUSE -> IDLE if run=0.
//   busy=0 in PAUSE.
//  MPROC_SEQ_STEP_EN undefined: no step port, no PAUSE; EXEC goes directly to FETCH.
// STRUCTURE
//  Package mproc_pkg:
//   state encodings ST_IDLE..ST_ERR (and ST_PAUSE);
//   ins_class constants CLS_ALU=2'b00, CLS_LDI=2'b01, CLS_JMP=2'b10, CLS_HLT=2'b11.
//  Sub-module mproc_seq_wdog: 8-bit wait counter with clear/inc; expired = (count == WAIT_MAX-1) & inc.
//  Top: state register, next-state logic, output decode, instr_cnt register.
// TESTING
//  1. run=1, mem_ack tied 1, class ALU x4: load_ir, then wr_reg+pc_inc, every 3 cycles; instr_cnt=4.
//  2. mem_ack delayed 5 cycles on one fetch: mem_req held 6 cycles; load_ir only with ack; no pc_inc until its EXEC.
//  3. mem_ack never arrives, WAIT_MAX=15: err_to=1 after 15 FETCH cycles; mem_req=0; state stays ERR until reset=0.
//  4. class HLT: halted=1, no pc_inc, instr_cnt unchanged; run 1->0->1 resumes with FETCH.
//  5. run dropped during FETCH of a JUMP: fetch completes, jump_en+pc_inc issued once, then IDLE.
//  6. CNT_W=4, 17 instructions: instr_cnt wraps to 1; reset asserted mid-DECODE -> outputs 0 immediately.

Source files
------------

// File: rtl/mproc_pkg.sv
// Shared state encodings, instruction-class codes and class decode helpers for the mproc sequencer.
package mproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERR    = 3'd5,
        ST_PAUSE  = 3'd6
    } state_t;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LDI = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_HLT = 2'b11;

    function automatic logic cls_writes_reg(input logic [1:0] cls);
        return (cls == CLS_ALU) || (cls == CLS_LDI);
    endfunction

    function automatic logic cls_retires(input logic [1:0] cls);
        return (cls != CLS_HLT);
    endfunction

endpackage

// File: rtl/mproc_seq_wdog.sv
// Fetch wait-state watchdog: counts consecutive un-acknowledged FETCH cycles.
module mproc_seq_wdog
    import mproc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 8'(WAIT_MAX - 1)) && inc;

endmodule

// File: rtl/mproc_seq.sv
// Fetch/decode/execute sequencer for the mproc datapath with run/halt control and retire counter.
// Optional single-step mode (step input, PAUSE state) is built when MPROC_SEQ_STEP_EN is defined.
module mproc_seq
    import mproc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef MPROC_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [1:0]       ins_class,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             load_ir,
    output logic             pc_inc,
    output logic             wr_reg,
    output logic             jump_en,
    output logic             busy,
    output logic             halted,
    output logic             err_to,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               pc_inc_q, pc_inc_d;
    logic               wr_reg_q, wr_reg_d;
    logic               jump_en_q, jump_en_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               err_to_q, err_to_d;
    logic               in_fetch_s;
    logic               wd_expired_s;

    assign in_fetch_s = (state_q == ST_FETCH);

    mproc_seq_wdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_fetch_s || mem_ack),
        .inc     (in_fetch_s && !mem_ack),
        .expired (wd_expired_s)
    );

    // Next-state and retire-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
                else     state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (mem_ack)           state_d = ST_DECODE;
                else if (wd_expired_s) state_d = ST_ERR;
                else                   state_d = ST_FETCH;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (cls_retires(ins_class)) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef MPROC_SEQ_STEP_EN
                    if (run) state_d = ST_PAUSE;
                    else     state_d = ST_IDLE;
`else
                    if (run) state_d = ST_FETCH;
                    else     state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!run) state_d = ST_IDLE;
                else      state_d = ST_HALTED;
            end
            ST_ERR: state_d = ST_ERR;
`ifdef MPROC_SEQ_STEP_EN
            ST_PAUSE: begin
                if (!run)      state_d = ST_IDLE;
                else if (step) state_d = ST_FETCH;
                else           state_d = ST_PAUSE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state; IR is already loaded when EXEC is entered
    always_comb begin
        mem_req_d = 1'b0;
        pc_inc_d  = 1'b0;
        wr_reg_d  = 1'b0;
        jump_en_d = 1'b0;
        busy_d    = 1'b0;
        halted_d  = 1'b0;
        err_to_d  = 1'b0;
        case (state_d)
            ST_FETCH: begin
                mem_req_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_DECODE: busy_d = 1'b1;
            ST_EXEC: begin
                busy_d    = 1'b1;
                wr_reg_d  = cls_writes_reg(ins_class);
                pc_inc_d  = cls_retires(ins_class);
                jump_en_d = (ins_class == CLS_JMP);
            end
            ST_HALTED: halted_d = 1'b1;
            ST_ERR:    err_to_d = 1'b1;
            default:   busy_d   = 1'b0;
        endcase
    end

    // State, counter and registered output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            pc_inc_q  <= 1'b0;
            wr_reg_q  <= 1'b0;
            jump_en_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= mem_req_d;
            pc_inc_q  <= pc_inc_d;
            wr_reg_q  <= wr_reg_d;
            jump_en_q <= jump_en_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            err_to_q  <= err_to_d;
        end
    end

    // IR strobe must coincide with the acknowledged data beat, so it is decoded combinationally
    assign load_ir   = in_fetch_s && mem_ack;
    assign mem_req   = mem_req_q;
    assign pc_inc    = pc_inc_q;
    assign wr_reg    = wr_reg_q;
    assign jump_en   = jump_en_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err_to    = err_to_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mproc_seq.sv
// Scoreboard bench for mproc_seq: stimulus queues expected strobe groups, a monitor pops and checks them.
module tb_mproc_seq;
    import mproc_pkg::*;

    localparam int CNT_W = 4;
    localparam logic [3:0] V_LOAD  = 4'b1000;
    localparam logic [3:0] V_WRPC  = 4'b0110;
    localparam logic [3:0] V_JMPPC = 4'b0011;

    typedef struct {
        logic [3:0] vec;
        int         gap;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             mem_ack = 1'b0;
    logic [1:0]       d_in = CLS_ALU;
    logic [1:0]       ir_q = CLS_ALU;
    logic             mem_req, load_ir, pc_inc, wr_reg, jump_en, busy, halted, err_to;
    logic [CNT_W-1:0] instr_cnt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   mcnt;

    mproc_seq #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
`ifdef MPROC_SEQ_STEP_EN
        .step      (step),
`endif
        .ins_class (ir_q),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .load_ir   (load_ir),
        .pc_inc    (pc_inc),
        .wr_reg    (wr_reg),
        .jump_en   (jump_en),
        .busy      (busy),
        .halted    (halted),
        .err_to    (err_to),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath IR model: captures memory data on the load strobe
    always @(posedge clk or negedge reset) begin
        if (!reset) ir_q <= CLS_ALU;
        else if (load_ir) ir_q <= d_in;
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [3:0] v, input int g);
        exp_t e;
        e.vec = v;
        e.gap = g;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_sb(input int n, input int budget, input string name);
        int b;
        b = budget;
        while (sb.size() > n && b > 0) begin
            tick(1);
            b--;
        end
        chk(name, (sb.size() > n) ? 1 : 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        mem_ack = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    // Monitor: every cycle with any strobe must match the head of the scoreboard
    always @(negedge clk) begin
        logic [3:0] v;
        exp_t       e;
        v = {load_ir, wr_reg, pc_inc, jump_en};
        if (v != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", int'(v), 0);
            end else begin
                e = sb.pop_front();
                chk("strobes", int'(v), int'(e.vec));
                if (e.gap >= 0) chk("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("reset_outs", int'({mem_req, load_ir, pc_inc, wr_reg, jump_en, busy, halted, err_to}), 0);
        chk("reset_cnt", int'(instr_cnt), 0);

        // 1: four ALU instructions, zero wait states
        d_in = CLS_ALU;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(V_LOAD, (i == 0) ? -1 : 1);
            push(V_WRPC, 2);
        end
        run = 1'b1;
        wait_sb(1, 40, "t1_progress");
        run = 1'b0;
        wait_sb(0, 10, "t1_done");
        tick(2);
        chk("t1_cnt", int'(instr_cnt), 4);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: acknowledge delayed by 5 cycles
        do_reset();
        d_in = CLS_LDI;
        push(V_LOAD, -1);
        push(V_WRPC, 2);
        run = 1'b1;
        tick(1);
        mcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req) mcnt++;
            if (i == 5) mem_ack = 1'b1;
            tick(1);
        end
        mem_ack = 1'b0;
        run = 1'b0;
        chk("t2_req_cycles", mcnt, 6);
        chk("t2_req_drop", int'(mem_req), 0);
        wait_sb(0, 10, "t2_done");
        tick(2);
        chk("t2_cnt", int'(instr_cnt), 1);

        // 3: acknowledge never arrives -> timeout error
        do_reset();
        run = 1'b1;
        mcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (mem_req) mcnt++;
            if (i == 14) chk("t3_err_early", int'(err_to), 0);
            if (i == 15) chk("t3_err_set", int'(err_to), 1);
        end
        chk("t3_req_cycles", mcnt, 15);
        chk("t3_req_low", int'(mem_req), 0);
        run = 1'b0;
        mem_ack = 1'b1;
        tick(4);
        chk("t3_err_sticky", int'({err_to, busy, halted, mem_req}), 8);
        reset = 1'b0;
        #1;
        chk("t3_err_cleared", int'(err_to), 0);
        mem_ack = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);

        // 4: HALT, then run low/high resumes with a fetch
        d_in = CLS_HLT;
        mem_ack = 1'b1;
        push(V_LOAD, -1);
        run = 1'b1;
        mcnt = 0;
        while (!halted && mcnt < 10) begin
            tick(1);
            mcnt++;
        end
        chk("t4_halted", int'({halted, busy}), 2);
        chk("t4_cnt", int'(instr_cnt), 0);
        tick(3);
        chk("t4_stay_halted", int'({halted, mem_req}), 2);
        d_in = CLS_ALU;
        run = 1'b0;
        tick(1);
        chk("t4_leave_halt", int'(halted), 0);
        push(V_LOAD, -1);
        push(V_WRPC, 2);
        run = 1'b1;
        wait_sb(1, 10, "t4_resume");
        run = 1'b0;
        wait_sb(0, 10, "t4_done");
        tick(2);
        chk("t4_cnt_after", int'(instr_cnt), 1);

        // 5: run dropped during FETCH of a JUMP
        do_reset();
        d_in = CLS_JMP;
        push(V_LOAD, -1);
        push(V_JMPPC, 2);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(2);
        chk("t5_req_held", int'(mem_req), 1);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        wait_sb(0, 10, "t5_done");
        tick(3);
        chk("t5_idle", int'({busy, mem_req}), 0);
        chk("t5_cnt", int'(instr_cnt), 1);

        // 6: 17 instructions wrap a 4-bit counter, then reset in DECODE
        do_reset();
        d_in = CLS_LDI;
        mem_ack = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(V_LOAD, (i == 0) ? -1 : 1);
            push(V_WRPC, 2);
        end
        run = 1'b1;
        wait_sb(1, 80, "t6_progress");
        run = 1'b0;
        wait_sb(0, 10, "t6_done");
        tick(2);
        chk("t6_wrap", int'(instr_cnt), 1);
        push(V_LOAD, -1);
        run = 1'b1;
        wait_sb(0, 10, "t6_fetch");
        chk("t6_in_decode", int'({busy, mem_req}), 2);
        reset = 1'b0;
        #1;
        chk("t6_reset_outs", int'({mem_req, load_ir, pc_inc, wr_reg, jump_en, busy, halted, err_to}), 0);
        chk("t6_reset_cnt", int'(instr_cnt), 0);
        run = 1'b0;
        mem_ack = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
